char_string_pixel_sequencer: RTL and testbench

//  Generates the pixel walk for a string of fixed-size text glyphs on the VGA path. Parametrised

---
 rtl/char_string_pixel_sequencer_pkg.sv | 26 ++
 rtl/char_string_pixel_sequencer_glyph_pixel_counter.sv | 67 ++++++
 rtl/char_string_pixel_sequencer.sv | 146 ++++++++++++++
 tb/tb_char_string_pixel_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/char_string_pixel_sequencer_pkg.sv
// Shared definitions for the character-string pixel sequencer.
//  - seq_state_t : sequencer FSM states (IDLE / DRAW / DONE)
//  - DEF_*       : default glyph geometry and string length
//  - clog2_min1  : ceil(log2(value)), never less than 1, for sizing counters
package char_string_pixel_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int DEF_CHAR_W    = 8;
  localparam int DEF_CHAR_H    = 8;
  localparam int DEF_MAX_CHARS = 16;

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/char_string_pixel_sequencer_glyph_pixel_counter.sv
// glyph_pixel_counter: row-major pixel walk inside one glyph.
//  i_clock  : clock, rising edge
//  i_reset  : asynchronous active-high reset
//  i_clear  : synchronous return to pixel (0,0)
//  i_en     : advance one pixel (pixel accepted downstream)
//  o_px     : column within glyph
//  o_py     : row within glyph
//  o_offset : py*CHAR_W+px, kept as its own register
//  o_last   : current pixel is the last of the glyph
module glyph_pixel_counter
  import char_string_pixel_sequencer_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int CHAR_H = DEF_CHAR_H,
  localparam int PX_W  = clog2_min1(CHAR_W),
  localparam int PY_W  = clog2_min1(CHAR_H),
  localparam int PO_W  = clog2_min1(CHAR_W * CHAR_H)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_en,
  output logic [PX_W-1:0] o_px,
  output logic [PY_W-1:0] o_py,
  output logic [PO_W-1:0] o_offset,
  output logic            o_last
);

  logic [PX_W-1:0] r_px;
  logic [PY_W-1:0] r_py;
  logic [PO_W-1:0] r_offset;
  logic            w_px_last;
  logic            w_py_last;
  logic            w_last;

  assign w_px_last = (r_px == PX_W'(CHAR_W - 1));
  assign w_py_last = (r_py == PY_W'(CHAR_H - 1));
  assign w_last    = w_px_last & w_py_last;

  // Row-major order means the flat offset simply counts up by one per
  // accepted pixel, so no multiplier is needed to keep it in step.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_px     <= '0;
      r_py     <= '0;
      r_offset <= '0;
    end else if (i_clear) begin
      r_px     <= '0;
      r_py     <= '0;
      r_offset <= '0;
    end else if (i_en) begin
      if (w_px_last) begin
        r_px <= '0;
        r_py <= w_py_last ? '0 : r_py + PY_W'(1);
      end else begin
        r_px <= r_px + PX_W'(1);
      end
      r_offset <= w_last ? '0 : r_offset + PO_W'(1);
    end
  end

  assign o_px     = r_px;
  assign o_py     = r_py;
  assign o_offset = r_offset;
  assign o_last   = w_last;

endmodule

// File: rtl/char_string_pixel_sequencer.sv
// char_string_pixel_sequencer: pixel walk over a string of fixed-size glyphs.
//  i_clock          : clock, rising edge
//  i_reset          : asynchronous active-high reset
//  i_start          : begin a string (only honoured in IDLE)
//  i_num_chars      : characters to draw, latched on start, clamped to MAX_CHARS
//  i_abort          : cancel the current string, back to IDLE next edge
//  i_pixel_ready    : downstream takes the current pixel this cycle
//  o_pixel_valid    : char_index/px/py/offset describe a pixel to write
//  o_char_index     : current character, 0-based
//  o_px, o_py       : column / row within the glyph
//  o_pixel_offset   : py*CHAR_W+px (font-ROM bit address)
//  o_finished_char  : one-cycle pulse after the last pixel of a character is taken
//  o_done           : one-cycle pulse when the string is complete
//  o_busy           : high in DRAW and DONE
module char_string_pixel_sequencer
  import char_string_pixel_sequencer_pkg::*;
#(
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int CHAR_H    = DEF_CHAR_H,
  parameter int MAX_CHARS = DEF_MAX_CHARS,
  localparam int PX_W     = clog2_min1(CHAR_W),
  localparam int PY_W     = clog2_min1(CHAR_H),
  localparam int PO_W     = clog2_min1(CHAR_W * CHAR_H),
  localparam int IDX_W    = clog2_min1(MAX_CHARS),
  localparam int CNT_W    = clog2_min1(MAX_CHARS + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_chars,
  input  logic             i_abort,
  input  logic             i_pixel_ready,
  output logic             o_pixel_valid,
  output logic [IDX_W-1:0] o_char_index,
  output logic [PX_W-1:0]  o_px,
  output logic [PY_W-1:0]  o_py,
  output logic [PO_W-1:0]  o_pixel_offset,
  output logic             o_finished_char,
  output logic             o_done,
  output logic             o_busy
);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_char_index;
  logic             r_valid;
  logic             r_busy;
  logic             r_finished;
  logic             r_done;

  logic             w_accept;
  logic             w_clear;
  logic             w_glyph_last;
  logic             w_last_char;
  logic [CNT_W-1:0] w_clamped;

  // abort wins over an accept presented in the same cycle
  assign w_accept  = (r_state == ST_DRAW) & i_pixel_ready & ~i_abort;
  assign w_clear   = ((r_state == ST_DRAW) & i_abort) | (r_state == ST_DONE);
  assign w_clamped = (i_num_chars > CNT_W'(MAX_CHARS)) ? CNT_W'(MAX_CHARS) : i_num_chars;
  assign w_last_char = ((CNT_W'(r_char_index) + CNT_W'(1)) == r_count);

  glyph_pixel_counter #(
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_glyph (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_clear),
    .i_en     (w_accept),
    .o_px     (o_px),
    .o_py     (o_py),
    .o_offset (o_pixel_offset),
    .o_last   (w_glyph_last)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_char_index <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            r_count <= w_clamped;
            r_busy  <= 1'b1;
            if (w_clamped == '0) begin
              // empty string: skip straight to the completion pulse
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DRAW;
              r_valid <= 1'b1;
            end
          end
        end
        ST_DRAW: begin
          if (i_abort) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_count      <= '0;
            r_char_index <= '0;
          end else if (w_accept && w_glyph_last) begin
            r_finished <= 1'b1;
            if (w_last_char) begin
              r_state      <= ST_DONE;
              r_valid      <= 1'b0;
              r_done       <= 1'b1;
              r_char_index <= '0;
            end else begin
              r_char_index <= r_char_index + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_count      <= '0;
          r_char_index <= '0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_valid      <= 1'b0;
          r_busy       <= 1'b0;
          r_count      <= '0;
          r_char_index <= '0;
        end
      endcase
    end
  end

  assign o_pixel_valid   = r_valid;
  assign o_char_index    = r_char_index;
  assign o_finished_char = r_finished;
  assign o_done          = r_done;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_char_string_pixel_sequencer.sv
module tb_char_string_pixel_sequencer;

  // ---------------- default-geometry instance (8x8, 16 chars) ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] num;
  logic       abort;
  logic       ready;
  logic       valid;
  logic [3:0] cidx;
  logic [2:0] px;
  logic [2:0] py;
  logic [5:0] offs;
  logic       fin;
  logic       done;
  logic       busy;

  // ---------------- 5x7 instance ----------------
  logic       s_start;
  logic [4:0] s_num;
  logic       s_abort;
  logic       s_ready;
  logic       s_valid;
  logic [3:0] s_cidx;
  logic [2:0] s_px;
  logic [2:0] s_py;
  logic [5:0] s_offs;
  logic       s_fin;
  logic       s_done;
  logic       s_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  char_string_pixel_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_num_chars(num),
    .i_abort(abort), .i_pixel_ready(ready), .o_pixel_valid(valid),
    .o_char_index(cidx), .o_px(px), .o_py(py), .o_pixel_offset(offs),
    .o_finished_char(fin), .o_done(done), .o_busy(busy)
  );

  char_string_pixel_sequencer #(.CHAR_W(5), .CHAR_H(7), .MAX_CHARS(16)) dut_small (
    .i_clock(clk), .i_reset(rst), .i_start(s_start), .i_num_chars(s_num),
    .i_abort(s_abort), .i_pixel_ready(s_ready), .o_pixel_valid(s_valid),
    .o_char_index(s_cidx), .o_px(s_px), .o_py(s_py), .o_pixel_offset(s_offs),
    .o_finished_char(s_fin), .o_done(s_done), .o_busy(s_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pick_ready(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return (cyc % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fin"}, fin, 0);
  endtask

  // One string on the 8x8 instance. The expected pixel for the k-th accept
  // is derived from k alone: char = k/64, px = k%8, py = (k%64)/8.
  task automatic run_string(input int n, input int mode, input int abort_at,
                            input bit busy_start,
                            output int acc, output int fins, output int dones);
    int eff, total, cyc, off, bound;
    bit fin_exp, aborted, r;
    eff = (n > 16) ? 16 : n;
    total = eff * 64;
    bound = total * 20 + 100;
    acc = 0; fins = 0; dones = 0; cyc = 0; fin_exp = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1; num = 5'(n); abort = 1'b0; ready = pick_ready(mode, 0);
    @(negedge clk);
    start = 1'b0;
    if (total == 0) begin
      chk("empty_valid", valid, 0);
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 1);
      dones += int'(done);
      @(negedge clk);
      chk_idle("empty_after");
      return;
    end
    while (acc < total) begin
      if (cyc > bound) begin
        chk("timeout_accepts", acc, total);
        return;
      end
      off = acc % 64;
      chk("valid", valid, 1);
      chk("char_index", cidx, acc / 64);
      chk("px", px, off % 8);
      chk("py", py, off / 8);
      chk("offset", offs, off);
      chk("finished_char", fin, int'(fin_exp));
      chk("done_mid", done, 0);
      chk("busy", busy, 1);
      fins += int'(fin);
      dones += int'(done);
      if (abort_at >= 0 && acc == abort_at) begin
        abort = 1'b1; ready = 1'b1; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        chk("abort_px", px, 0);
        chk("abort_offset", offs, 0);
        chk("abort_char", cidx, 0);
        @(negedge clk);
        chk_idle("abort_hold");
        aborted = 1;
        break;
      end
      r = pick_ready(mode, cyc);
      ready = r;
      start = (busy_start && acc == 10) ? 1'b1 : 1'b0;
      num = busy_start ? 5'd3 : num;
      fin_exp = 0;
      if (r) begin
        acc++;
        fin_exp = (acc % 64) == 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!aborted) begin
      chk("final_valid", valid, 0);
      chk("final_fin", fin, 1);
      chk("final_done", done, 1);
      chk("final_busy", busy, 1);
      fins += int'(fin);
      dones += int'(done);
      @(negedge clk);
      chk_idle("final_after");
    end
  endtask

  typedef struct {
    int n;
    int mode;
    int abort_at;
    bit busy_start;
    int exp_acc;
    int exp_fins;
    int exp_dones;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int acc, fins, dones, n, k, sfins, sdones, smax, cyc;
    bit r;

    tbl[0] = '{n: 2,  mode: 0, abort_at: -1, busy_start: 0, exp_acc: 128,  exp_fins: 2,  exp_dones: 1};
    tbl[1] = '{n: 1,  mode: 1, abort_at: -1, busy_start: 0, exp_acc: 64,   exp_fins: 1,  exp_dones: 1};
    tbl[2] = '{n: 0,  mode: 0, abort_at: -1, busy_start: 0, exp_acc: 0,    exp_fins: 0,  exp_dones: 1};
    tbl[3] = '{n: 3,  mode: 2, abort_at: 30, busy_start: 1, exp_acc: 30,   exp_fins: 0,  exp_dones: 0};
    tbl[4] = '{n: 20, mode: 2, abort_at: -1, busy_start: 0, exp_acc: 1024, exp_fins: 16, exp_dones: 1};

    rst = 1'b1; start = 0; num = 0; abort = 0; ready = 0;
    s_start = 0; s_num = 0; s_abort = 0; s_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_offset", offs, 0);
    rst = 1'b0;

    // reset asserted in the middle of a glyph
    @(negedge clk);
    start = 1'b1; num = 5'd1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_reset_offset", offs, 40);
    chk("pre_reset_py", py, 5);
    rst = 1'b1;
    #1;
    chk_idle("async_reset");
    chk("async_reset_offset", offs, 0);
    chk("async_reset_py", py, 0);
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_string(tbl[i].n, tbl[i].mode, tbl[i].abort_at, tbl[i].busy_start, acc, fins, dones);
      chk($sformatf("tbl%0d_accepts", i), acc, tbl[i].exp_acc);
      chk($sformatf("tbl%0d_fins", i), fins, tbl[i].exp_fins);
      chk($sformatf("tbl%0d_dones", i), dones, tbl[i].exp_dones);
      $display("string %0d: n=%0d accepts=%0d finished=%0d done=%0d", i, tbl[i].n, acc, fins, dones);
    end

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 17);
      run_string(n, 2, -1, 0, acc, fins, dones);
      chk("rnd_accepts", acc, ((n > 16) ? 16 : n) * 64);
      chk("rnd_fins", fins, (n > 16) ? 16 : n);
      chk("rnd_dones", dones, 1);
      $display("random string %0d: n=%0d accepts=%0d finished=%0d done=%0d", i, n, acc, fins, dones);
    end

    // 5x7 glyphs, 20 requested -> 16 drawn
    @(negedge clk);
    s_start = 1'b1; s_num = 5'd20;
    @(negedge clk);
    s_start = 1'b0;
    k = 0; sfins = 0; sdones = 0; smax = 0; cyc = 0;
    while (cyc < 20000) begin
      sfins += int'(s_fin);
      sdones += int'(s_done);
      if (s_done) break;
      if (s_valid) begin
        if (int'(s_offs) > smax) smax = int'(s_offs);
        if (s_offs != 6'(k % 35) || s_px != 3'((k % 35) % 5) || s_py != 3'((k % 35) / 5)
            || s_cidx != 4'(k / 35))
          chk("small_pixel", int'(s_offs), k % 35);
      end
      r = 1'($urandom_range(0, 1));
      s_ready = r;
      if (r && s_valid) k++;
      @(negedge clk);
      cyc++;
    end
    s_ready = 1'b0;
    chk("small_accepts", k, 560);
    chk("small_fins", sfins, 16);
    chk("small_offset_max", smax, 34);
    chk("small_dones", sdones, 1);
    $display("5x7 string: accepts=%0d finished=%0d max_offset=%0d done=%0d", k, sfins, smax, sdones);
    @(negedge clk);
    chk("small_busy_after", s_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
